// File: rtl/layer_loader.sv
// ---------------------------------------------------------------------------
// layer_loader
//
// Purpose:
//   Streams the parameter words of one neural-network layer from a
//   valid/ready source into the per-node shift registers. Each of the sl
//   nodes receives sx+1 words in source order: weights w0..w(sx-1) first,
//   then the bias b, so the bias ends up at the top of the node's data.
//   Every accepted word (a "beat") is registered onto bus. For exactly the
//   following cycle, the one-hot node enable we selects the node that owns
//   the word.
//
// Configuration macro:
//   LAYER_LOADER_ABORT_EN - when defined, adds the abort input. An abort in
//                           LOAD or FIN returns the loader to IDLE and drops
//                           the word offered in that cycle.
//
// Word width:
//   `FXP_N normally comes from the fixed-point header. A 16-bit default is
//   provided here so the module elaborates on its own. The bus is
//   2*`FXP_N bits wide.
//
// Ports:
//   clk       in   clock, rising-edge active
//   rst       in   asynchronous active-low reset
//   start     in   begin a full layer load (sampled only in IDLE)
//   abort     in   (LAYER_LOADER_ABORT_EN only) cancel the current load
//   in_data   in   parameter word from the source
//   in_valid  in   in_data is valid
//   in_ready  out  loader accepts a word this cycle (high only in LOAD)
//   we        out  per-node shift enable; node j uses we[sl-1-j]
//   bus       out  word presented to the node shift registers
//   busy      out  high while in LOAD
//   done      out  one-cycle pulse, coincident with the final we pulse
//   node_idx  out  node currently being loaded
//   word_idx  out  index of the next word for that node
// ---------------------------------------------------------------------------
`ifndef FXP_N
`define FXP_N 16
`endif

module layer_loader #(
    parameter int sx = 4,
    parameter int sl = 3
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic                                      start,
`ifdef LAYER_LOADER_ABORT_EN
    input  logic                                      abort,
`endif
    input  logic [2*`FXP_N-1:0]                       in_data,
    input  logic                                      in_valid,
    output logic                                      in_ready,
    output logic [sl-1:0]                             we,
    output logic [2*`FXP_N-1:0]                       bus,
    output logic                                      busy,
    output logic                                      done,
    output logic [((sl > 1) ? $clog2(sl) : 1)-1:0]    node_idx,
    output logic [$clog2(sx+1)-1:0]                   word_idx
);

    localparam int NW = (sl > 1) ? $clog2(sl) : 1;
    localparam int WW = $clog2(sx + 1);
    localparam int BW = 2 * `FXP_N;

    // The enable for node 0 is the MSB, so node k's enable is this value
    // shifted right by k.
    localparam logic [sl-1:0] WE_NODE0 = sl'(1) << (sl - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [NW-1:0]   node_q, node_d;
    logic [WW-1:0]   word_q, word_d;
    logic [sl-1:0]   we_q, we_d;
    logic [BW-1:0]   bus_q, bus_d;

    logic            abort_w;
    logic            beat;
    logic            last_word;
    logic            last_node;

`ifdef LAYER_LOADER_ABORT_EN
    assign abort_w = abort;
`else
    assign abort_w = 1'b0;
`endif

    // An abort wins over a simultaneous beat, so that word is never taken.
    assign beat      = in_valid && (state_q == S_LOAD) && !abort_w;
    assign last_word = (word_q == WW'(sx));
    assign last_node = (node_q == NW'(sl - 1));

    // -----------------------------------------------------------------------
    // FSM: state register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // -----------------------------------------------------------------------
    // FSM: next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                if (abort_w) begin
                    state_d = S_IDLE;
                end else if (beat && last_word && last_node) begin
                    state_d = S_FIN;
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // FSM: outputs decoded from state
    // FIN lasts one cycle: the cycle after the final beat. That is also
    // the cycle in which the final we pulse is on the bus.
    // -----------------------------------------------------------------------
    always_comb begin
        in_ready = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                in_ready = 1'b0;
            end
            S_LOAD: begin
                in_ready = 1'b1;
                busy     = 1'b1;
            end
            S_FIN: begin
                done     = 1'b1;
            end
            default: begin
                in_ready = 1'b0;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Datapath next-state: counters, node enable, bus capture
    // -----------------------------------------------------------------------
    always_comb begin
        node_d = node_q;
        word_d = word_q;
        we_d   = '0;
        bus_d  = bus_q;

        if ((state_q != S_LOAD) || abort_w) begin
            // Counters are only meaningful during LOAD. A load always
            // restarts from node 0, word 0.
            node_d = '0;
            word_d = '0;
        end else if (beat) begin
            bus_d = in_data;
            we_d  = WE_NODE0 >> node_q;
            if (last_word) begin
                word_d = '0;
                // The final beat clears the node counter rather than
                // stepping past the last node.
                node_d = last_node ? '0 : node_q + NW'(1);
            end else begin
                word_d = word_q + WW'(1);
            end
        end
    end

    // -----------------------------------------------------------------------
    // Datapath registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            node_q <= '0;
            word_q <= '0;
            we_q   <= '0;
            bus_q  <= '0;
        end else begin
            node_q <= node_d;
            word_q <= word_d;
            we_q   <= we_d;
            bus_q  <= bus_d;
        end
    end

    assign we       = we_q;
    assign bus      = bus_q;
    assign node_idx = node_q;
    assign word_idx = word_q;

endmodule

// File: tb/tb_layer_loader.sv
`timescale 1ns/1ps
`ifndef FXP_N
`define FXP_N 16
`endif

module tb_layer_loader;

    localparam int BW = 2 * `FXP_N;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // DUT A: sx=2, sl=2
    logic          start_a, valid_a, ready_a, busy_a, done_a, abort_a;
    logic [BW-1:0] data_a, bus_a;
    logic [1:0]    we_a;
    logic [0:0]    node_a;
    logic [1:0]    word_a;

    // DUT B: sx=1, sl=3
    logic          start_b, valid_b, ready_b, busy_b, done_b, abort_b;
    logic [BW-1:0] data_b, bus_b;
    logic [2:0]    we_b;
    logic [1:0]    node_b;
    logic [0:0]    word_b;

    layer_loader #(.sx(2), .sl(2)) dut_a (
        .clk(clk), .rst(rst), .start(start_a),
`ifdef LAYER_LOADER_ABORT_EN
        .abort(abort_a),
`endif
        .in_data(data_a), .in_valid(valid_a), .in_ready(ready_a),
        .we(we_a), .bus(bus_a), .busy(busy_a), .done(done_a),
        .node_idx(node_a), .word_idx(word_a)
    );

    layer_loader #(.sx(1), .sl(3)) dut_b (
        .clk(clk), .rst(rst), .start(start_b),
`ifdef LAYER_LOADER_ABORT_EN
        .abort(abort_b),
`endif
        .in_data(data_b), .in_valid(valid_b), .in_ready(ready_b),
        .we(we_b), .bus(bus_b), .busy(busy_b), .done(done_b),
        .node_idx(node_b), .word_idx(word_b)
    );

    typedef struct {
        logic          start;
        logic          valid;
        logic [BW-1:0] data;
        logic [1:0]    we;
        logic [BW-1:0] bus;
        logic          busy;
        logic          done;
        logic [0:0]    node;
        logic [1:0]    word;
    } vec_t;

    int n_vec = 0;
    int n_err = 0;
    int pulses_a = 0;
    int dones_a = 0;
    logic [BW+1:0] sbq[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor for DUT A: every we pulse must match the next
    // expected {we, bus} pushed when the beat was driven.
    always @(posedge clk) begin
        logic [BW+1:0] e;
        #2;
        if (we_a != 2'b00) begin
            pulses_a++;
            if (sbq.size() == 0) begin
                chk("sb_unexpected_we", {we_a, bus_a}, 64'h0);
            end else begin
                e = sbq.pop_front();
                chk("sb_we_bus", {we_a, bus_a}, e);
            end
        end
        if (done_a) dones_a++;
    end

    vec_t          vecs[8];
    logic [2:0]    exp_b[6];
    logic [1:0]    ew;
    logic [BW-1:0] last_d, d;
    int            k, p0, d0;

    initial begin
        rst = 1'b0;
        start_a = 0; valid_a = 0; data_a = '0; abort_a = 0;
        start_b = 0; valid_b = 0; data_b = '0; abort_b = 0;

        vecs[0] = '{1'b1, 1'b0, 32'h0,  2'b00, 32'h0,  1'b1, 1'b0, 1'b0, 2'd0};
        vecs[1] = '{1'b0, 1'b1, 32'h11, 2'b10, 32'h11, 1'b1, 1'b0, 1'b0, 2'd1};
        vecs[2] = '{1'b0, 1'b1, 32'h22, 2'b10, 32'h22, 1'b1, 1'b0, 1'b0, 2'd2};
        vecs[3] = '{1'b0, 1'b1, 32'h33, 2'b10, 32'h33, 1'b1, 1'b0, 1'b1, 2'd0};
        vecs[4] = '{1'b0, 1'b1, 32'h44, 2'b01, 32'h44, 1'b1, 1'b0, 1'b1, 2'd1};
        vecs[5] = '{1'b0, 1'b1, 32'h55, 2'b01, 32'h55, 1'b1, 1'b0, 1'b1, 2'd2};
        vecs[6] = '{1'b0, 1'b1, 32'h66, 2'b01, 32'h66, 1'b0, 1'b1, 1'b0, 2'd0};
        vecs[7] = '{1'b0, 1'b0, 32'h0,  2'b00, 32'h66, 1'b0, 1'b0, 1'b0, 2'd0};
        exp_b = '{3'b100, 3'b100, 3'b010, 3'b010, 3'b001, 3'b001};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_we", we_a, 0);
        chk("rst_bus", bus_a, 0);
        chk("rst_ready", ready_a, 0);
        chk("rst_busy", busy_a, 0);
        chk("rst_done", done_a, 0);
        chk("rst_idx", {node_a, word_a}, 0);
        #3 rst = 1'b1;

        // Nominal load, table-driven
        for (int i = 0; i < 8; i++) begin
            start_a = vecs[i].start;
            valid_a = vecs[i].valid;
            data_a  = vecs[i].data;
            if (vecs[i].we != 2'b00) sbq.push_back({vecs[i].we, vecs[i].bus});
            step();
            chk($sformatf("nom%0d_we", i), we_a, vecs[i].we);
            chk($sformatf("nom%0d_bus", i), bus_a, vecs[i].bus);
            chk($sformatf("nom%0d_busy", i), busy_a, vecs[i].busy);
            chk($sformatf("nom%0d_ready", i), ready_a, vecs[i].busy);
            chk($sformatf("nom%0d_done", i), done_a, vecs[i].done);
            chk($sformatf("nom%0d_node", i), node_a, vecs[i].node);
            chk($sformatf("nom%0d_word", i), word_a, vecs[i].word);
        end
        chk("nom_pulses", pulses_a, 6);
        chk("nom_dones", dones_a, 1);

        // Stalls: in_valid toggles 1,0,1,0...
        p0 = pulses_a; d0 = dones_a;
        start_a = 1; valid_a = 0;
        step();
        start_a = 0;
        k = 0; last_d = 32'h66;
        for (int i = 0; i < 12; i++) begin
            valid_a = (i % 2 == 0);
            d = BW'($urandom);
            data_a = d;
            ew = 2'b00;
            if (valid_a) begin
                ew = 2'b10 >> (k / 3);
                sbq.push_back({ew, d});
                last_d = d;
                k++;
            end
            step();
            chk($sformatf("stall%0d_we", i), we_a, ew);
            chk($sformatf("stall%0d_bus", i), bus_a, last_d);
            chk($sformatf("stall%0d_node", i), node_a, (k == 6) ? 0 : k / 3);
            chk($sformatf("stall%0d_word", i), word_a, (k == 6) ? 0 : k % 3);
            chk($sformatf("stall%0d_done", i), done_a, (i == 10));
        end
        valid_a = 0;
        chk("stall_pulses", pulses_a - p0, 6);
        chk("stall_dones", dones_a - d0, 1);

        // start held high through LOAD and FIN
        p0 = pulses_a; d0 = dones_a;
        start_a = 1;
        step();
        for (int i = 0; i < 6; i++) begin
            valid_a = 1; data_a = BW'(32'h100 + i);
            sbq.push_back({2'b10 >> (i / 3), BW'(32'h100 + i)});
            step();
        end
        start_a = 0; valid_a = 0;
        step();
        step();
        chk("ign_busy", busy_a, 0);
        chk("ign_pulses", pulses_a - p0, 6);
        chk("ign_dones", dones_a - d0, 1);

        // Mid-load reset after beat 4
        start_a = 1;
        step();
        start_a = 0;
        for (int i = 0; i < 4; i++) begin
            valid_a = 1; data_a = BW'(32'h200 + i);
            sbq.push_back({2'b10 >> (i / 3), BW'(32'h200 + i)});
            step();
        end
        #2 rst = 1'b0;
        valid_a = 0;
        #1;
        chk("mrst_we", we_a, 0);
        chk("mrst_bus", bus_a, 0);
        chk("mrst_idx", {node_a, word_a}, 0);
        chk("mrst_busy", {busy_a, ready_a}, 0);
        chk("mrst_sb_empty", sbq.size(), 0);
        sbq.delete();
        #2 rst = 1'b1;
        p0 = pulses_a; d0 = dones_a;
        step();
        start_a = 1;
        step();
        start_a = 0;
        for (int i = 0; i < 6; i++) begin
            valid_a = 1; data_a = BW'(32'h300 + i);
            sbq.push_back({2'b10 >> (i / 3), BW'(32'h300 + i)});
            step();
            if (i == 0) chk("mrst_first_we", {we_a, bus_a}, {2'b10, BW'(32'h300)});
        end
        valid_a = 0;
        step();
        chk("mrst_pulses", pulses_a - p0, 6);
        chk("mrst_dones", dones_a - d0, 1);

`ifdef LAYER_LOADER_ABORT_EN
        // Abort together with beat 3
        p0 = pulses_a; d0 = dones_a;
        start_a = 1;
        step();
        start_a = 0;
        for (int i = 0; i < 2; i++) begin
            valid_a = 1; data_a = BW'(32'h400 + i);
            sbq.push_back({2'b10, BW'(32'h400 + i)});
            step();
        end
        valid_a = 1; data_a = BW'(32'h402); abort_a = 1;
        step();
        abort_a = 0; valid_a = 0;
        chk("abort_we", we_a, 0);
        chk("abort_bus", bus_a, 32'h401);
        chk("abort_ready", {busy_a, ready_a}, 0);
        chk("abort_idx", {node_a, word_a}, 0);
        step();
        chk("abort_pulses", pulses_a - p0, 2);
        chk("abort_dones", dones_a - d0, 0);
`endif

        // Node order on sl=3, sx=1
        start_b = 1;
        step();
        start_b = 0;
        for (int i = 0; i < 6; i++) begin
            valid_b = 1; data_b = BW'(32'h500 + i);
            step();
            chk($sformatf("order%0d_we", i), we_b, exp_b[i]);
            chk($sformatf("order%0d_bus", i), bus_b, 32'h500 + i);
        end
        valid_b = 0;
        chk("order_done", done_b, 1);
        step();
        chk("order_idle", {we_b, busy_b, done_b}, 0);

        chk("sb_drained", sbq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
